// File: rtl/freq_meter.sv
// Gated pulse-counting frequency meter.
// Counts pulse_in highs over a fixed gate window, snapshots the count on the
// terminal cycle, converts it to packed BCD with a sequential shift-add-3
// engine and holds binary/BCD results on a valid/ready interface.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned CNT_WIDTH   = 24,
    parameter int unsigned BCD_DIGITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse_in,
    output logic                    gate_tick,
    output logic [CNT_WIDTH-1:0]    result_bin,
    output logic [4*BCD_DIGITS-1:0] result_bcd,
    output logic                    overflow,
    output logic                    valid,
    input  logic                    ready,
    output logic                    dropped
);

    localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned StepW = $clog2(CNT_WIDTH + 1);
    localparam int unsigned BcdW  = 4 * BCD_DIGITS;

    localparam logic [GateW-1:0]     GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [StepW-1:0]     StepLast = StepW'(CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    typedef enum logic [1:0] {StIdle, StConvert, StHold} state_e;

    state_e               state_q, state_d;
    logic [GateW-1:0]     gate_cnt_q;
    logic [CNT_WIDTH-1:0] pulse_cnt_q, cnt_inc;
    logic                 sat_q, sat_inc;
    logic [StepW-1:0]     step_q, step_d;
    logic [BcdW-1:0]      bcd_sr_q, bcd_sr_d, bcd_adj, bcd_shift;
    logic [CNT_WIDTH-1:0] bin_sr_q, bin_sr_d, bin_shift;
    logic [CNT_WIDTH-1:0] snap_bin_q, snap_bin_d;
    logic                 snap_sat_q, snap_sat_d;
    logic [CNT_WIDTH-1:0] result_bin_q, result_bin_d;
    logic [BcdW-1:0]      result_bcd_q, result_bcd_d;
    logic                 overflow_q, overflow_d;
    logic                 dropped_q, dropped_d;
    logic                 handshake;

    assign gate_tick  = (gate_cnt_q == GateLast);
    assign valid      = (state_q == StHold);
    assign handshake  = valid && ready;
    assign result_bin = result_bin_q;
    assign result_bcd = result_bcd_q;
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;

    // Gate window counter: free-running 0..GATE_CYCLES-1, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_q <= '0;
        end else if (gate_tick) begin
            gate_cnt_q <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_q + GateW'(1);
        end
    end

    // Pulse count including this cycle's pulse; doubles as the snapshot value.
    // The saturation flag marks a pulse that could not be counted.
    always_comb begin
        cnt_inc = pulse_cnt_q;
        sat_inc = sat_q;
        if (pulse_in) begin
            if (pulse_cnt_q == CntMax) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = pulse_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Pulse counter restarts right after the terminal cycle so no pulse is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt_q <= '0;
            sat_q       <= 1'b0;
        end else if (gate_tick) begin
            pulse_cnt_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            pulse_cnt_q <= cnt_inc;
            sat_q       <= sat_inc;
        end
    end

    // One double-dabble step: add 3 to digits >= 5, then shift binary MSB into BCD LSB.
    always_comb begin
        bcd_adj = bcd_sr_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_shift, bin_shift} = {bcd_adj, bin_sr_q} << 1;
    end

    // Next-state logic: snapshot acceptance, conversion sequencing, result hold.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        bcd_sr_d     = bcd_sr_q;
        bin_sr_d     = bin_sr_q;
        snap_bin_d   = snap_bin_q;
        snap_sat_d   = snap_sat_q;
        result_bin_d = result_bin_q;
        result_bcd_d = result_bcd_q;
        overflow_d   = overflow_q;
        dropped_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gate_tick) begin
                    state_d    = StConvert;
                    step_d     = '0;
                    bcd_sr_d   = '0;
                    bin_sr_d   = cnt_inc;
                    snap_bin_d = cnt_inc;
                    snap_sat_d = sat_inc;
                end
            end
            StConvert: begin
                bcd_sr_d = bcd_shift;
                bin_sr_d = bin_shift;
                step_d   = step_q + StepW'(1);
                if (step_q == StepLast) begin
                    state_d      = StHold;
                    result_bin_d = snap_bin_q;
                    result_bcd_d = bcd_shift;
                    overflow_d   = snap_sat_q;
                end
                if (gate_tick) begin
                    dropped_d = 1'b1;
                end
            end
            StHold: begin
                if (handshake) begin
                    state_d = StIdle;
                    // Consume and accept in the same edge: go straight back to converting.
                    if (gate_tick) begin
                        state_d    = StConvert;
                        step_d     = '0;
                        bcd_sr_d   = '0;
                        bin_sr_d   = cnt_inc;
                        snap_bin_d = cnt_inc;
                        snap_sat_d = sat_inc;
                    end
                end else if (gate_tick) begin
                    dropped_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM, conversion datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            step_q       <= '0;
            bcd_sr_q     <= '0;
            bin_sr_q     <= '0;
            snap_bin_q   <= '0;
            snap_sat_q   <= 1'b0;
            result_bin_q <= '0;
            result_bcd_q <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            bcd_sr_q     <= bcd_sr_d;
            bin_sr_q     <= bin_sr_d;
            snap_bin_q   <= snap_bin_d;
            snap_sat_q   <= snap_sat_d;
            result_bin_q <= result_bin_d;
            result_bcd_q <= result_bcd_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: directed window sequence with randomized pulse
// densities, checked against an arithmetic model of each window's result.
module tb_freq_meter;

    localparam int unsigned G     = 80;
    localparam int unsigned CW    = 6;
    localparam int unsigned BD    = 2;
    localparam int          CMAX  = (1 << CW) - 1;

    typedef struct {
        int bin;
        int bcd;
        bit ovf;
    } res_t;

    logic            clk;
    logic            rst;
    logic            pulse_in;
    logic            gate_tick;
    logic [CW-1:0]   result_bin;
    logic [4*BD-1:0] result_bcd;
    logic            overflow;
    logic            valid;
    logic            ready;
    logic            dropped;

    int n_run  = 0;
    int n_fail = 0;
    int win_no = 0;
    int cyc_no = 0;

    freq_meter #(
        .GATE_CYCLES(G),
        .CNT_WIDTH  (CW),
        .BCD_DIGITS (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .gate_tick (gate_tick),
        .result_bin(result_bin),
        .result_bcd(result_bcd),
        .overflow  (overflow),
        .valid     (valid),
        .ready     (ready),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s (window %0d cycle %0d): observed %0h expected %0h",
                   tag, win_no, cyc_no, got, exp);
        end
    endtask

    // Expected result of a window with cnt pulses: saturating count, decimal digits.
    function automatic res_t calc(input int cnt);
        res_t r;
        int   v;
        r.ovf = (cnt > CMAX);
        r.bin = r.ovf ? CMAX : cnt;
        r.bcd = 0;
        v     = r.bin;
        for (int d = 0; d < BD; d++) begin
            r.bcd = r.bcd | ((v % 10) << (4 * d));
            v     = v / 10;
        end
        return r;
    endfunction

    // Runs ncyc cycles of a gate window. pmode: 0 none, 1 all, 2 every 4th (incl.
    // terminal cycle), 3 random 1/2, 4 random 1/4. rmode: 0 ready high, 1 ready low,
    // 2 ready high only on the terminal cycle. arrive: prev result appears at cycle 6.
    // held: prev result already valid for the whole window. drop0: dropped at cycle 0.
    task automatic run_window(input int pmode, input int rmode, input bit arrive,
                              input bit held, input bit drop0, input res_t prev,
                              input int ncyc, output res_t res);
        int   cnt;
        bit   p;
        bit   rd;
        bit   exp_v;
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc_no = i;
            if (held) exp_v = 1'b1;
            else if (arrive) exp_v = (rmode == 0) ? (i == 6) : (i >= 6);
            else exp_v = 1'b0;
            check("gate_tick", 32'(gate_tick), 32'(i == G - 1));
            check("valid", 32'(valid), 32'(exp_v));
            check("dropped", 32'(dropped), 32'(drop0 && i == 0));
            if (exp_v) begin
                check("result_bin", 32'(result_bin), prev.bin);
                check("result_bcd", 32'(result_bcd), prev.bcd);
                check("overflow", 32'(overflow), 32'(prev.ovf));
            end
            case (pmode)
                0:       p = 1'b0;
                1:       p = 1'b1;
                2:       p = (i % 4 == 3);
                3:       p = ($urandom % 2) == 1;
                default: p = ($urandom % 4) == 0;
            endcase
            case (rmode)
                0:       rd = 1'b1;
                1:       rd = 1'b0;
                default: rd = (i == G - 1);
            endcase
            pulse_in = p;
            ready    = rd;
            cnt      = cnt + int'(p);
            @(negedge clk);
        end
        res = calc(cnt);
        win_no++;
    endtask

    // Asynchronous reset mid-cycle: every output must clear without a clock edge.
    task automatic do_reset();
        rst      = 1'b1;
        pulse_in = 1'b1;
        #1;
        check("rst_gate_tick", 32'(gate_tick), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_result_bin", 32'(result_bin), 32'd0);
        check("rst_result_bcd", 32'(result_bcd), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        res_t none;
        res_t r1, r2, r3, r4, rp, rx, rc, rd, re, rf, rg, rh, junk;
        none.bin = 0;
        none.bcd = 0;
        none.ovf = 1'b0;

        rst      = 1'b1;
        pulse_in = 1'b0;
        ready    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_gate_tick", 32'(gate_tick), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_dropped", 32'(dropped), 32'd0);
        check("reset_result_bin", 32'(result_bin), 32'd0);
        check("reset_result_bcd", 32'(result_bcd), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Continuous pulses saturate; silence reports zero; every 4th counts terminal pulse.
        run_window(1, 0, 1'b0, 1'b0, 1'b0, none, G, r1);
        check("model_sat_bin", 32'(r1.bin), 32'd63);
        run_window(0, 0, 1'b1, 1'b0, 1'b0, r1, G, r2);
        run_window(2, 0, 1'b1, 1'b0, 1'b0, r2, G, r3);
        run_window(3, 0, 1'b1, 1'b0, 1'b0, r3, G, r4);
        rp = r4;
        for (int k = 0; k < 4; k++) begin
            run_window((k % 2 == 0) ? 4 : 3, 0, 1'b1, 1'b0, 1'b0, rp, G, rx);
            rp = rx;
        end

        // Backpressure: first result held, two snapshots dropped, then handshake on tick.
        run_window(4, 1, 1'b1, 1'b0, 1'b0, rp, G, junk);
        run_window(3, 1, 1'b0, 1'b1, 1'b1, rp, G, junk);
        run_window(1, 2, 1'b0, 1'b1, 1'b1, rp, G, rc);
        run_window(2, 0, 1'b1, 1'b0, 1'b0, rc, G, rd);

        // Reset in the middle of a conversion, then in the middle of a window.
        run_window(3, 0, 1'b1, 1'b0, 1'b0, rd, G, re);
        run_window(3, 0, 1'b1, 1'b0, 1'b0, re, 4, junk);
        do_reset();
        run_window(4, 0, 1'b0, 1'b0, 1'b0, none, G, rf);
        run_window(3, 0, 1'b1, 1'b0, 1'b0, rf, 40, junk);
        do_reset();
        run_window(1, 0, 1'b0, 1'b0, 1'b0, none, G, rg);
        run_window(0, 0, 1'b1, 1'b0, 1'b0, rg, G, rh);
        run_window(0, 0, 1'b1, 1'b0, 1'b0, rh, 10, junk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated pulse-counting frequency meter that consumes the single-cycle carry pulses of the phase-accumulator stage. It counts clock cycles on which `pulse_in` is high over a fixed gate window, snapshots the count at the end of each window, converts it to packed BCD with a sequential shift-add-3 engine, and presents binary and BCD results on a valid/ready interface to the display/readout stage.

## Interface
- `GATE_CYCLES`, default 100000: gate window length in `clk` cycles; legal range ≥ 2.
- `CNT_WIDTH`, default 24: width of the pulse counter and binary result.
- `BCD_DIGITS`, default 8: number of BCD digits; must satisfy 10^BCD_DIGITS > 2^CNT_WIDTH − 1.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pulse_in`  in  1  pulse stream, synchronous to `clk`; each cycle high counts as one event, including back-to-back highs.
- `gate_tick`  out  1  one-cycle strobe on the last cycle of each gate window.
- `result_bin`  out  CNT_WIDTH  binary count of the reported window.
- `result_bcd`  out  4*BCD_DIGITS  packed BCD of `result_bin`; digit 0 in bits [3:0].
- `overflow`  out  1  reported window saturated.
- `valid`  out  1  result outputs hold a complete, unconsumed measurement.
- `ready`  in  1  consumer accepts the result when `valid && ready` at a rising edge.
- `dropped`  out  1  one-cycle strobe: a window snapshot was discarded.

## Operation
- Gate counter runs 0..GATE_CYCLES−1 and wraps; `gate_tick` is high while it equals GATE_CYCLES−1.
- Pulse counter increments on each cycle with `pulse_in`=1 and saturates at 2^CNT_WIDTH−1, setting a per-window saturation flag.
- Terminal cycle (`gate_tick`=1): snapshot = counter value including that cycle's `pulse_in`, plus the saturation flag; the pulse counter and flag restart at 0 on the next cycle, so no pulse is lost or double-counted across windows.
- The FSM has three states:
  - IDLE: on snapshot, load the shift register and go to CONVERT.
  - CONVERT: runs exactly CNT_WIDTH cycles. Each cycle, add 3 to every BCD digit ≥ 5, then shift left 1, taking the binary MSB into the BCD LSB. It then goes to HOLD with `valid`=1.
  - HOLD: `result_*` and `overflow` stay stable. A `valid && ready` edge returns to IDLE.
- A snapshot arriving in CONVERT, or in HOLD without a same-cycle handshake, is discarded and `dropped` pulses the next cycle. The held/in-flight result is unaffected.
- Simultaneous handshake and snapshot in HOLD: the result is consumed, the snapshot is accepted, and the FSM goes HOLD→CONVERT directly. `valid` is low the following cycle; `dropped` is not asserted.
- Reset values: `valid`, `gate_tick`, `dropped`, `overflow` = 0; `result_bin`, `result_bcd` = 0; all counters 0; FSM IDLE.
- `rst` asserted mid-window or mid-conversion aborts immediately. The first window after release is a full GATE_CYCLES long.

## Timing
- Snapshot taken at the edge ending terminal cycle T. CONVERT occupies cycles T+1..T+CNT_WIDTH. `valid` rises at the edge ending cycle T+CNT_WIDTH, with outputs updated on the same edge.
- `valid` falls on the edge that completes the handshake. Outputs do not change while `valid`=1.
- `ready` is not required to wait for `valid`; `ready` with `valid`=0 has no effect.
- Throughput: one result per window when GATE_CYCLES > CNT_WIDTH+1 and the consumer returns `ready` promptly.
- `gate_tick` is independent of FSM state and backpressure.

## Test plan
- Test 1: GATE_CYCLES=100, `pulse_in` held 1, `ready`=1 → every window reports `result_bin`=100, `result_bcd`=0x00000100, `overflow`=0, with `valid` 24 cycles after `gate_tick`.
- Test 2: `pulse_in` high every 4th cycle (carry pattern of the accumulator with increment 2^30), GATE_CYCLES=100 → 25 / 0x00000025 each window; the boundary pulse falling on the terminal cycle is counted in the closing window.
- Test 3: CNT_WIDTH=6, BCD_DIGITS=2, GATE_CYCLES=100, `pulse_in`=1 → `result_bin`=63, `result_bcd`=0x63, `overflow`=1; the next window with `pulse_in`=0 → 0, `overflow`=0.
- Test 4: `ready`=0 across three windows → the first result is held stable, `dropped` pulses twice. Raising `ready` on the same cycle as the next `gate_tick` → handshake completes, that window is converted, no drop.
- Test 5: assert `rst` midway through CONVERT and midway through a window → all outputs 0 asynchronously. After release, the first `gate_tick` comes exactly GATE_CYCLES cycles later and its result counts only post-reset pulses.
